interrupt_sequencer: RTL and testbench

Controller that arbitrates the 6502C interrupt sources (RES, NMI, IRQ, BRK) and sequences the seven-cycle interrupt entry: IR override, three stack cycles, two vector fetches. Sits between the pin latches and the random-control/address logic; owns NMI edge capture, priority, vector selection and the "handled" pulses.

---
 rtl/cpu_int_pkg.sv | 49 ++++
 rtl/nmi_edge_detect.sv | 37 +++
 rtl/interrupt_sequencer.sv | 159 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_int_pkg.sv
// ---------------------------------------------------------------------------
// cpu_int_pkg : shared state/source encodings and default vectors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_int_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_HOLD = 4'd1,
    ST_S0   = 4'd2,
    ST_S1   = 4'd3,
    ST_S2   = 4'd4,
    ST_S3   = 4'd5,
    ST_S4   = 4'd6,
    ST_S5   = 4'd7,
    ST_S6   = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_e;

  localparam logic [1:0] C_PUSH_PCH  = 2'd0;
  localparam logic [1:0] C_PUSH_PCL  = 2'd1;
  localparam logic [1:0] C_PUSH_P    = 2'd2;
  localparam logic [1:0] C_PUSH_NONE = 2'd3;

  localparam logic [15:0] C_VEC_NMI = 16'hFFFA;
  localparam logic [15:0] C_VEC_RES = 16'hFFFC;
  localparam logic [15:0] C_VEC_IRQ = 16'hFFFE;

  // S0..S6 are contiguous in the encoding, so the step is an offset from S0.
  function automatic logic [2:0] step_of(input state_e s);
    logic [3:0] w_off;
    w_off = s - ST_S0;
    if (s inside {ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6})
      return w_off[2:0];
    else
      return 3'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nmi_edge_detect.sv
// ---------------------------------------------------------------------------
// nmi_edge_detect : NMI falling-edge capture with set-wins pending clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nmi_edge_detect (
  input  logic phi1,
  input  logic rstAll,
  input  logic nmiL_i,
  input  logic clr_i,
  output logic edge_o,
  output logic req_o
);

  logic sample_q;
  logic pend_q;
  logic pend_d;

  assign edge_o = sample_q & ~nmiL_i;
  // An edge seen this cycle counts as pending so a coincident poll takes it.
  assign req_o  = pend_q | edge_o;
  assign pend_d = edge_o | (pend_q & ~clr_i);

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      sample_q <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      sample_q <= nmiL_i;
      pend_q   <= pend_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// interrupt_sequencer : 6502C RES/NMI/IRQ/BRK arbitration and 7-cycle entry
// Optional feature macro: NMI_HIJACK_EN (late NMI steals IRQ/BRK vector)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interrupt_sequencer
  import cpu_int_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = C_VEC_NMI,
  parameter logic [15:0] VEC_RES = C_VEC_RES,
  parameter logic [15:0] VEC_IRQ = C_VEC_IRQ
) (
  input  logic        phi1,
  input  logic        rstAll,
  input  logic        NMI_L,
  input  logic        IRQ_L,
  input  logic        RES_L,
  input  logic        iFlag,
  input  logic        rdy,
  input  logic        instrDone,
  input  logic        brkOp,
  output logic        busy,
  output logic        forceBrk,
  output logic [2:0]  step,
  output logic        stackCyc,
  output logic        stackWr,
  output logic [1:0]  pushSel,
  output logic        pushB,
  output logic        vecFetch,
  output logic [15:0] vecAddr,
  output logic        setI,
  output logic        nmiHandled,
  output logic        irqHandled,
  output logic        resHandled
);

  state_e      state_q;
  src_e        src_q;
  src_e        w_vecSrc;
  logic        w_nmiEdge;
  logic        w_nmiReq;
  logic        w_irqPend;
  logic        w_adv;
  logic        w_done;
  logic        w_hijack;
  logic [15:0] w_vecBase;

  nmi_edge_detect u_nmi (
    .phi1   (phi1),
    .rstAll (rstAll),
    .nmiL_i (NMI_L),
    .clr_i  (nmiHandled),
    .edge_o (w_nmiEdge),
    .req_o  (w_nmiReq)
  );

  assign w_irqPend = ~IRQ_L & ~iFlag;

  // Stack writes for hardware/BRK sources ignore RDY; everything else reads.
  always_comb begin
    w_adv = rdy;
    if ((state_q inside {ST_S2, ST_S3, ST_S4}) && (src_q != SRC_RES))
      w_adv = 1'b1;
  end

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_IRQ;
    end else if (!RES_L) begin
      state_q <= ST_HOLD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instrDone && rdy && (w_nmiReq || w_irqPend)) begin
            state_q <= ST_S0;
            src_q   <= w_nmiReq ? SRC_NMI : SRC_IRQ;
          end else if (brkOp && rdy) begin
            state_q <= ST_S1;
            src_q   <= SRC_BRK;
          end
        end
        ST_HOLD: begin
          state_q <= ST_S0;
          src_q   <= SRC_RES;
        end
        ST_S6: begin
          if (rdy) state_q <= ST_IDLE;
        end
        default: begin
          if (w_adv) state_q <= state_e'(state_q + 4'd1);
        end
      endcase
    end
  end

`ifdef NMI_HIJACK_EN
  logic hijack_q;

  always_ff @(posedge phi1 or posedge rstAll) begin
    if (rstAll) begin
      hijack_q <= 1'b0;
    end else if (!RES_L || (state_q == ST_IDLE) || (state_q == ST_HOLD)) begin
      hijack_q <= 1'b0;
    end else if (w_nmiEdge && (state_q inside {ST_S0, ST_S1, ST_S2, ST_S3, ST_S4})
                 && (src_q inside {SRC_IRQ, SRC_BRK})) begin
      hijack_q <= 1'b1;
    end
  end

  assign w_hijack = hijack_q;
`else
  logic w_unusedEdge;
  assign w_unusedEdge = w_nmiEdge;
  assign w_hijack     = 1'b0;
`endif

  assign w_vecSrc = w_hijack ? SRC_NMI : src_q;

  always_comb begin
    w_vecBase = VEC_IRQ;
    case (w_vecSrc)
      SRC_RES: w_vecBase = VEC_RES;
      SRC_NMI: w_vecBase = VEC_NMI;
      default: w_vecBase = VEC_IRQ;
    endcase
  end

  always_comb begin
    pushSel = C_PUSH_NONE;
    case (state_q)
      ST_S2:   pushSel = C_PUSH_PCH;
      ST_S3:   pushSel = C_PUSH_PCL;
      ST_S4:   pushSel = C_PUSH_P;
      default: pushSel = C_PUSH_NONE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign forceBrk = (state_q == ST_S0);
  assign step     = step_of(state_q);
  assign stackCyc = (state_q inside {ST_S2, ST_S3, ST_S4});
  assign stackWr  = stackCyc & (src_q != SRC_RES);
  assign pushB    = busy & (src_q == SRC_BRK);
  assign vecFetch = (state_q == ST_S5) || (state_q == ST_S6);
  assign vecAddr  = w_vecBase + {15'd0, (state_q == ST_S6)};

  // A reset assertion in S6 aborts the entry, so completion also needs RES_L.
  assign w_done     = (state_q == ST_S6) & rdy & RES_L;
  assign setI       = w_done;
  assign resHandled = w_done & (src_q == SRC_RES);
  assign nmiHandled = w_done & ((src_q == SRC_NMI) | w_hijack);
  assign irqHandled = w_done & (src_q == SRC_IRQ) & ~w_hijack;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_interrupt_sequencer : directed self-checking bench for interrupt_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_sequencer;

  logic        phi1 = 1'b0;
  logic        rstAll;
  logic        NMI_L, IRQ_L, RES_L, iFlag, rdy, instrDone, brkOp;
  logic        busy, forceBrk, stackCyc, stackWr, pushB, vecFetch, setI;
  logic        nmiHandled, irqHandled, resHandled;
  logic [2:0]  step;
  logic [1:0]  pushSel;
  logic [15:0] vecAddr;

  int nChecks = 0;
  int nErrors = 0;

`ifdef NMI_HIJACK_EN
  localparam bit HIJACK = 1'b1;
`else
  localparam bit HIJACK = 1'b0;
`endif

  interrupt_sequencer dut (
    .phi1       (phi1),
    .rstAll     (rstAll),
    .NMI_L      (NMI_L),
    .IRQ_L      (IRQ_L),
    .RES_L      (RES_L),
    .iFlag      (iFlag),
    .rdy        (rdy),
    .instrDone  (instrDone),
    .brkOp      (brkOp),
    .busy       (busy),
    .forceBrk   (forceBrk),
    .step       (step),
    .stackCyc   (stackCyc),
    .stackWr    (stackWr),
    .pushSel    (pushSel),
    .pushB      (pushB),
    .vecFetch   (vecFetch),
    .vecAddr    (vecAddr),
    .setI       (setI),
    .nmiHandled (nmiHandled),
    .irqHandled (irqHandled),
    .resHandled (resHandled)
  );

  always #5 phi1 = ~phi1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge phi1);
    #1;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".hnd"}, {29'd0, nmiHandled, irqHandled, resHandled}, 32'd0);
  endtask

  // Walks from the current step through S6; hnd = {nmi, irq, res}.
  task automatic walk(input string tag, input int first, input logic [15:0] vec,
                      input logic [2:0] hnd, input bit wr, input bit pb);
    for (int s = first; s <= 6; s++) begin
      chk($sformatf("%s.s%0d.step", tag, s), {29'd0, step}, s);
      chk($sformatf("%s.s%0d.busy", tag, s), {31'd0, busy}, 32'd1);
      chk($sformatf("%s.s%0d.fbrk", tag, s), {31'd0, forceBrk}, (s == 0) ? 32'd1 : 32'd0);
      if (s >= 2 && s <= 4) begin
        chk($sformatf("%s.s%0d.wr", tag, s), {31'd0, stackWr}, {31'd0, wr});
        chk($sformatf("%s.s%0d.psel", tag, s), {30'd0, pushSel}, s - 2);
        chk($sformatf("%s.s%0d.pushB", tag, s), {31'd0, pushB}, {31'd0, pb});
      end else begin
        chk($sformatf("%s.s%0d.psel", tag, s), {30'd0, pushSel}, 32'd3);
      end
      if (s >= 5) begin
        chk($sformatf("%s.s%0d.vec", tag, s), {16'd0, vecAddr},
            {16'd0, vec} + ((s == 6) ? 32'd1 : 32'd0));
        chk($sformatf("%s.s%0d.vf", tag, s), {31'd0, vecFetch}, 32'd1);
      end
      chk($sformatf("%s.s%0d.hnd", tag, s), {29'd0, nmiHandled, irqHandled, resHandled},
          (s == 6) ? {29'd0, hnd} : 32'd0);
      chk($sformatf("%s.s%0d.setI", tag, s), {31'd0, setI}, (s == 6) ? 32'd1 : 32'd0);
      cyc();
    end
    chkIdle({tag, ".end"});
  endtask

  initial begin
    rstAll = 1'b1; NMI_L = 1'b1; IRQ_L = 1'b1; RES_L = 1'b1;
    iFlag = 1'b1; rdy = 1'b1; instrDone = 1'b0; brkOp = 1'b0;
    cyc(); cyc();
    rstAll = 1'b0;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.step", {29'd0, step}, 32'd0);
    chk("rst.psel", {30'd0, pushSel}, 32'd3);
    chk("rst.vec", {16'd0, vecAddr}, 32'hFFFE);
    chk("rst.misc", {25'd0, forceBrk, stackCyc, stackWr, pushB, vecFetch, setI, resHandled}, 32'd0);

    // Reset pin held 3 cycles.
    RES_L = 1'b0;
    cyc();
    chk("res.hold.busy", {31'd0, busy}, 32'd1);
    chk("res.hold.step", {29'd0, step}, 32'd0);
    cyc(); cyc();
    chk("res.hold3.fbrk", {31'd0, forceBrk}, 32'd0);
    RES_L = 1'b1;
    cyc();
    walk("res", 0, 16'hFFFC, 3'b001, 1'b0, 1'b0);

    // IRQ entry, then masked IRQ ignored.
    iFlag = 1'b0; IRQ_L = 1'b0; instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    walk("irq", 0, 16'hFFFE, 3'b010, 1'b1, 1'b0);
    iFlag = 1'b1; instrDone = 1'b1;
    cyc();
    chkIdle("irqmask");
    instrDone = 1'b0; IRQ_L = 1'b1;

    // NMI edge coincident with IRQ poll.
    iFlag = 1'b0; IRQ_L = 1'b0; NMI_L = 1'b0; instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    walk("nmi", 0, 16'hFFFA, 3'b100, 1'b1, 1'b0);
    instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    walk("irq2", 0, 16'hFFFE, 3'b010, 1'b1, 1'b0);
    IRQ_L = 1'b1; instrDone = 1'b1;
    cyc();
    chkIdle("nmiclr");
    instrDone = 1'b0; NMI_L = 1'b1;
    cyc();

    // BRK entry.
    brkOp = 1'b1;
    cyc();
    brkOp = 1'b0;
    walk("brk", 1, 16'hFFFE, 3'b000, 1'b1, 1'b1);

    // BRK with RDY low in S3 (no stall) and in S5 (stall).
    brkOp = 1'b1;
    cyc();
    brkOp = 1'b0;
    cyc();
    cyc();
    chk("brkrdy.s3", {29'd0, step}, 32'd3);
    rdy = 1'b0;
    cyc();
    chk("brkrdy.s3nostall", {29'd0, step}, 32'd4);
    rdy = 1'b1;
    cyc();
    chk("brkrdy.s5", {29'd0, step}, 32'd5);
    rdy = 1'b0;
    cyc();
    chk("brkrdy.stall1", {29'd0, step}, 32'd5);
    cyc();
    chk("brkrdy.stall2", {29'd0, step}, 32'd5);
    chk("brkrdy.stall.setI", {31'd0, setI}, 32'd0);
    rdy = 1'b1;
    cyc();
    chk("brkrdy.s6", {29'd0, step}, 32'd6);
    chk("brkrdy.s6.setI", {31'd0, setI}, 32'd1);
    chk("brkrdy.s6.hnd", {29'd0, nmiHandled, irqHandled, resHandled}, 32'd0);
    cyc();
    chkIdle("brkrdy.end");

    // NMI edge during IRQ S3.
    iFlag = 1'b0; IRQ_L = 1'b0; instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    cyc(); cyc(); cyc();
    chk("hij.s3", {29'd0, step}, 32'd3);
    NMI_L = 1'b0; IRQ_L = 1'b1;
    cyc();
    chk("hij.s4.pushB", {31'd0, pushB}, 32'd0);
    cyc();
    chk("hij.s5.vec", {16'd0, vecAddr}, HIJACK ? 32'hFFFA : 32'hFFFE);
    cyc();
    chk("hij.s6.vec", {16'd0, vecAddr}, HIJACK ? 32'hFFFB : 32'hFFFF);
    chk("hij.s6.hnd", {29'd0, nmiHandled, irqHandled, resHandled}, HIJACK ? 32'd4 : 32'd2);
    cyc();
    chkIdle("hij.end");
    instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    if (HIJACK) begin
      chkIdle("hij.nopend");
    end else begin
      walk("hij.late", 0, 16'hFFFA, 3'b100, 1'b1, 1'b0);
    end
    NMI_L = 1'b1;
    cyc();

    // RES_L asserted during S4 aborts the IRQ entry.
    IRQ_L = 1'b0; instrDone = 1'b1;
    cyc();
    instrDone = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("abort.s4", {29'd0, step}, 32'd4);
    RES_L = 1'b0; IRQ_L = 1'b1;
    cyc();
    chk("abort.hold.busy", {31'd0, busy}, 32'd1);
    chk("abort.hold.step", {29'd0, step}, 32'd0);
    chk("abort.hold.hnd", {29'd0, nmiHandled, irqHandled, resHandled}, 32'd0);
    cyc();
    RES_L = 1'b1;
    cyc();
    walk("abort.res", 0, 16'hFFFC, 3'b001, 1'b0, 1'b0);

    // Asynchronous reset mid-BRK.
    brkOp = 1'b1;
    cyc();
    brkOp = 1'b0;
    cyc(); cyc();
    chk("arst.s3", {29'd0, step}, 32'd3);
    rstAll = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.psel", {30'd0, pushSel}, 32'd3);
    chk("arst.vec", {16'd0, vecAddr}, 32'hFFFE);
    chk("arst.misc", {25'd0, forceBrk, stackCyc, stackWr, pushB, vecFetch, setI, step != 3'd0}, 32'd0);
    cyc();
    rstAll = 1'b0;
    cyc();
    chkIdle("arst.after");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
